// File: rtl/trace_uart_tx.sv
// rtl/trace_uart_tx.sv - Retired-instruction trace serializer: record FIFO plus 8N1 UART transmitter.
// Each record is a sync byte (0xA5 trace, 0x5A halt) followed by pc and inst, little-endian.
module trace_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trace_valid,
  input  logic [31:0] trace_pc,
  input  logic [31:0] trace_inst,
  input  logic        halt,
  output logic        uart_tx,
  output logic        fifo_full,
  output logic        overflow,
  output logic [15:0] drop_count,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   L_FULL    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] L_BIT_END = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [64:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_halt_q;
  logic          r_full;
  logic          r_busy;
  logic          r_overflow;
  logic [15:0]   r_drop_count;

  state_t        r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [3:0]    r_byte_idx;
  logic [71:0]   r_rec;
  logic          r_tx;

  logic          w_halt_ev;
  logic          w_push;
  logic          w_empty;
  logic          w_full_now;
  logic          w_bit_end;
  logic          w_rec_done;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;
  logic          w_to_idle;
  logic [64:0]   w_entry;
  logic [64:0]   w_rd;
  logic [71:0]   w_load;
  logic [AW:0]   w_count_next;

  assign w_halt_ev  = halt & ~r_halt_q;
  assign w_push     = trace_valid | w_halt_ev;
  assign w_entry    = {w_halt_ev,
                       trace_valid ? trace_pc   : 32'h0,
                       trace_valid ? trace_inst : 32'h0};
  assign w_empty    = (r_count == '0);
  assign w_full_now = (r_count == L_FULL);
  assign w_bit_end  = (r_clk_cnt == L_BIT_END);
  assign w_rec_done = (r_state == S_STOP) && w_bit_end && (r_byte_idx == 4'd8);
  assign w_pop      = ~w_empty && ((r_state == S_IDLE) || w_rec_done);
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok  = w_push && (~w_full_now || w_pop);
  assign w_drop     = w_push && w_full_now && ~w_pop;
  assign w_to_idle  = w_empty && ((r_state == S_IDLE) || w_rec_done);
  assign w_count_next = r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop};

  assign w_rd   = r_mem[r_rd_ptr];
  assign w_load = {w_rd[31:0], w_rd[63:32], w_rd[64] ? 8'h5A : 8'hA5};

  assign uart_tx    = r_tx;
  assign fifo_full  = r_full;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign busy       = r_busy;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_halt_q     <= 1'b0;
      r_full       <= 1'b0;
      r_busy       <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= 16'h0;
    end else begin
      r_halt_q <= halt;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == L_FULL);
      r_busy  <= (w_count_next != '0) || ~w_to_idle;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  // The line register follows the state one edge late, so every bit keeps its full width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 4'd0;
      r_rec      <= 72'h0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= r_rec[0];
        default: r_tx <= 1'b1;
      endcase
      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          if (w_pop) begin
            r_rec      <= w_load;
            r_byte_idx <= 4'd0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_idx <= 3'd0;
            r_state   <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_rec     <= {1'b0, r_rec[71:1]};
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
            else r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_byte_idx != 4'd8) begin
              r_byte_idx <= r_byte_idx + 4'd1;
              r_state    <= S_START;
            end else if (w_pop) begin
              r_rec      <= w_load;
              r_byte_idx <= 4'd0;
              r_state    <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_uart_tx.sv
// tb/tb_trace_uart_tx.sv - Self-checking bench for trace_uart_tx with a UART byte scoreboard.
module tb_trace_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trace_valid = 1'b0;
  logic [31:0] trace_pc = 32'h0;
  logic [31:0] trace_inst = 32'h0;
  logic        halt = 1'b0;
  logic        uart_tx;
  logic        fifo_full;
  logic        overflow;
  logic [15:0] drop_count;
  logic        busy;

  trace_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_inst(trace_inst), .halt(halt), .uart_tx(uart_tx), .fifo_full(fifo_full),
    .overflow(overflow), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
  bit mon_en = 1'b1;

  typedef struct {
    logic        valid;
    logic        hlt;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  exp_sync;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(input logic [7:0] sync, input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back(sync);
    for (int i = 0; i < 4; i++) exp_q.push_back(pc[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(inst[8*i +: 8]);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // UART receiver: samples mid-bit on falling edges and scores each byte.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && uart_tx == 1'b0) begin
        start_q.push_back(cyc);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        chk("stop_bit", {31'h0, uart_tx}, 32'h1);
        if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, b}, 32'hFFFF_FFFF);
        else chk("rx_byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lows;
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0050_0093, 8'hA5, 32'h0000_0004, 32'h0050_0093};
    vecs[1] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 8'hA5, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[2] = '{1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222, 8'h5A, 32'h0,         32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0073, 8'h5A, 32'h0000_0020, 32'h0000_0073};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 8'hA5, 32'hFFFF_FFFC, 32'hFFFF_FFFF};

    #12;
    chk("reset_tx", {31'h0, uart_tx}, 32'h1);
    chk("reset_full", {31'h0, fifo_full}, 32'h0);
    chk("reset_overflow", {31'h0, overflow}, 32'h0);
    chk("reset_drop_count", {16'h0, drop_count}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      start_q.delete();
      trace_valid = vecs[i].valid;
      halt        = vecs[i].hlt;
      trace_pc    = vecs[i].pc;
      trace_inst  = vecs[i].inst;
      n = cyc + 1;
      push_exp(vecs[i].exp_sync, vecs[i].exp_pc, vecs[i].exp_inst);
      @(negedge clk);
      trace_valid = 1'b0;
      if (vecs[i].hlt) begin
        repeat (100) @(negedge clk);
        halt = 1'b0;
      end
      wait_until(n + 300);
      chk("vec_busy_mid", {31'h0, busy}, 32'h1);
      wait_drain("vec_drain", 400);
      wait_until(n + 362);
      chk("vec_start_latency", (start_q.size() > 0) ? start_q[0] : -1, n + 2);
      chk("vec_byte_count", start_q.size(), 9);
      chk("vec_busy_end", {31'h0, busy}, 32'h0);
      chk("vec_line_idle", {31'h0, uart_tx}, 32'h1);
    end

    start_q.delete();
    n = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      trace_valid = 1'b1;
      trace_pc    = 32'(4 * k);
      trace_inst  = 32'h0000_0100 + 32'(k);
      push_exp(8'hA5, trace_pc, trace_inst);
      @(negedge clk);
    end
    trace_valid = 1'b0;
    wait_drain("b2b_drain", 1300);
    chk("b2b_byte_count", start_q.size(), 27);
    if (start_q.size() == 27) begin
      chk("b2b_first_start", start_q[0], n + 2);
      chk("b2b_gap_1", start_q[9] - start_q[0], 90 * CPB);
      chk("b2b_gap_2", start_q[18] - start_q[9], 90 * CPB);
    end
    wait_until(n + 3 * 90 * CPB + 3);
    chk("b2b_busy_end", {31'h0, busy}, 32'h0);

    n = cyc + 1;
    for (int k = 0; k < 10; k++) begin
      trace_valid = 1'b1;
      trace_pc    = 32'(4 * k);
      trace_inst  = 32'h0000_1000 + 32'(k);
      if (k < 5) push_exp(8'hA5, trace_pc, trace_inst);
      @(negedge clk);
      chk($sformatf("ovf_full_edge%0d", k), {31'h0, fifo_full}, (k >= 4) ? 32'h1 : 32'h0);
    end
    trace_valid = 1'b0;
    chk("ovf_drop_count", {16'h0, drop_count}, 32'd5);
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);
    wait_drain("ovf_drain", 5 * 90 * CPB + 100);
    wait_until(n + 5 * 90 * CPB + 3);
    chk("ovf_busy_end", {31'h0, busy}, 32'h0);
    chk("ovf_still_sticky", {31'h0, overflow}, 32'h1);

    mon_en = 1'b0;
    n = cyc + 1;
    trace_valid = 1'b1;
    trace_pc    = 32'h0;
    trace_inst  = 32'h0;
    @(negedge clk);
    trace_valid = 1'b0;
    wait_until(n + 99);
    chk("rst_pre_line_low", {31'h0, uart_tx}, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_tx", {31'h0, uart_tx}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_drop_count", {16'h0, drop_count}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("rst_line_quiet", lows, 0);
    mon_en = 1'b1;

    mon_en = 1'b0;
    trace_valid = 1'b1;
    repeat (1000) @(negedge clk);
    chk("sat_not_yet", {31'h0, (drop_count != 16'hFFFF)}, 32'h1);
    repeat (65000) @(negedge clk);
    trace_valid = 1'b0;
    @(negedge clk);
    chk("sat_drop_count", {16'h0, drop_count}, 32'h0000_FFFF);
    chk("sat_overflow", {31'h0, overflow}, 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
